// File: rtl/corr_pkg.sv
// corr_pkg
// Shared definitions for the correlation engine and its neighbours.
// The frame geometry is also used by the frame-save and search-controller
// blocks, so it is defined here once.
//   H_RES, V_RES  : frame size in pixels
//   PIX_W         : pixel width
//   DRAIN_CYCLES  : cycles needed to empty the multiply/accumulate pipeline
//   corr_state_t  : engine FSM states
package corr_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int PIX_W        = 8;
    localparam int DRAIN_CYCLES = 3;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        GAP
    } corr_state_t;

endpackage

// File: rtl/corr_mac.sv
// corr_mac
// Tag/product/saturating-accumulate pipeline for one correlation window.
// The valid tag arrives aligned with the read address. It is delayed one
// cycle so it lines up with the returned memory data. The product is then
// registered, and the product is added into the accumulator.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : zero the accumulator (start of a new window)
//   valid      : tap tag, aligned with the read address
//   frame_pix  : frame pixel, one cycle after its address
//   tmpl_pix   : template pixel, one cycle after its address
//   acc        : unsigned saturating sum of products
module corr_mac #(
    parameter int PIX_W = corr_pkg::PIX_W,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [PIX_W-1:0] frame_pix,
    input  logic [PIX_W-1:0] tmpl_pix,
    output logic [ACC_W-1:0] acc
);

    localparam int PROD_W = 2 * PIX_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic              mem_valid_q;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  sum;

    // Untagged taps (outside the frame) contribute zero. The sum is formed
    // one bit wider than either operand so an overflow can be detected and
    // clamped instead of wrapping.
    always_comb begin
        prod_d = mem_valid_q ? (PROD_W'(frame_pix) * PROD_W'(tmpl_pix)) : '0;
        sum    = SUM_W'(acc_q) + SUM_W'(prod_q);
        acc_d  = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : ACC_W'(sum);
        if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
        end else begin
            mem_valid_q <= valid;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/correlation_engine.sv
// correlation_engine
// Responder side of the coordinate/correlation handshake. It latches a
// window origin and streams the template and the matching frame window out
// of synchronous memories. It accumulates the sum of pixel products and
// reports the result with a one-cycle pulse.
//   iCLK, iRST        : clock, asynchronous active-high reset
//   iX, iY            : window origin from the search controller
//   iControllerReady  : origin valid and frame stored
//   iFinished         : search complete, accept no more windows
//   oCorrFinished     : one-cycle pulse, oCurrentCorr valid
//   oCurrentCorr      : result of the last window (zero-extended)
//   oBusy             : window in progress (RUN and DRAIN)
//   oFrameAddr        : frame read address y*H_RES + x
//   iFramePixel       : frame data, one cycle after its address
//   oTmplAddr         : template read address, row-major
//   iTmplPixel        : template data, one cycle after its address
module correlation_engine #(
    parameter int H_RES  = corr_pkg::H_RES,
    parameter int V_RES  = corr_pkg::V_RES,
    parameter int TW     = 16,
    parameter int TH     = 16,
    parameter int PIX_W  = corr_pkg::PIX_W,
    parameter int ADDR_W = 19,
    parameter int ACC_W  = 32,
    localparam int TA_W  = $clog2(TW * TH)
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [12:0]       iX,
    input  logic [12:0]       iY,
    input  logic              iControllerReady,
    input  logic              iFinished,
    output logic              oCorrFinished,
    output logic [31:0]       oCurrentCorr,
    output logic              oBusy,
    output logic [ADDR_W-1:0] oFrameAddr,
    input  logic [PIX_W-1:0]  iFramePixel,
    output logic [TA_W-1:0]   oTmplAddr,
    input  logic [PIX_W-1:0]  iTmplPixel
);

    import corr_pkg::*;

    localparam int N = TW * TH;

    corr_state_t       state_q, state_d;
    logic [12:0]       org_x_q, org_x_d;
    logic [12:0]       org_y_q, org_y_d;
    logic [TA_W-1:0]   k_q, k_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [TA_W-1:0]   tmpl_addr_q, tmpl_addr_d;
    logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
    logic              tag_q, tag_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic [31:0]       corr_q, corr_d;
    logic              clear;
    logic              issue;
    logic [31:0]       next_x, next_y;
    logic [ACC_W-1:0]  acc;

    // Next-state and next-output logic. Every output is registered, so the
    // address for tap k is computed here from the origin and index that
    // will hold after the edge. This makes tap 0 appear right after the
    // latch edge.
    // GAP is also an accept point. The controller moves its origin on the
    // edge that ends DONE, so by GAP the origin is already fresh. Accepting
    // there gives back-to-back windows without an extra IDLE cycle.
    always_comb begin
        state_d      = state_q;
        org_x_d      = org_x_q;
        org_y_d      = org_y_q;
        k_d          = k_q;
        drain_d      = drain_q;
        tmpl_addr_d  = tmpl_addr_q;
        frame_addr_d = frame_addr_q;
        tag_d        = 1'b0;
        fin_d        = 1'b0;
        corr_d       = corr_q;
        clear        = 1'b0;
        issue        = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (iControllerReady && !iFinished) begin
                    state_d = RUN;
                    org_x_d = iX;
                    org_y_d = iY;
                    k_d     = '0;
                    clear   = 1'b1;
                    issue   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (k_q == TA_W'(N - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d   = k_q + TA_W'(1);
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                    fin_d   = 1'b1;
                    corr_d  = 32'(acc);
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = GAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        next_x = 32'(org_x_d) + (32'(k_d) % 32'(TW));
        next_y = 32'(org_y_d) + (32'(k_d) / 32'(TW));

        // Taps outside the frame keep the last legal frame address on the
        // bus and travel untagged, so they contribute nothing.
        if (issue) begin
            tmpl_addr_d = k_d;
            if ((next_x < 32'(H_RES)) && (next_y < 32'(V_RES))) begin
                frame_addr_d = ADDR_W'(next_y * 32'(H_RES) + next_x);
                tag_d        = 1'b1;
            end
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    // Single state register for the FSM, counters and registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= IDLE;
            org_x_q      <= '0;
            org_y_q      <= '0;
            k_q          <= '0;
            drain_q      <= '0;
            tmpl_addr_q  <= '0;
            frame_addr_q <= '0;
            tag_q        <= 1'b0;
            busy_q       <= 1'b0;
            fin_q        <= 1'b0;
            corr_q       <= '0;
        end else begin
            state_q      <= state_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            k_q          <= k_d;
            drain_q      <= drain_d;
            tmpl_addr_q  <= tmpl_addr_d;
            frame_addr_q <= frame_addr_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
            fin_q        <= fin_d;
            corr_q       <= corr_d;
        end
    end

    corr_mac #(
        .PIX_W(PIX_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk      (iCLK),
        .rst      (iRST),
        .clear    (clear),
        .valid    (tag_q),
        .frame_pix(iFramePixel),
        .tmpl_pix (iTmplPixel),
        .acc      (acc)
    );

    assign oCorrFinished = fin_q;
    assign oCurrentCorr  = corr_q;
    assign oBusy         = busy_q;
    assign oFrameAddr    = frame_addr_q;
    assign oTmplAddr     = tmpl_addr_q;

endmodule
